// File: rtl/frame_receiver_multi.sv
// rtl/frame_receiver_multi.sv - comma-delimited frame deframer with CRC-16/BUYPASS check, error counters and lock tracking
module frame_receiver_multi #(
    parameter int PAYLOAD_BYTES  = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int LOCK_FRAMES    = 4,
    parameter int UNLOCK_ERRORS  = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       word_tick_i,
    input  logic                       comma_i,
    input  logic [7:0]                 data_i,
    input  logic                       error_i,
    input  logic                       clear_counters_i,
    output logic                       frame_tick_o,
    output logic [PAYLOAD_BYTES*8-1:0] payload_o,
    output logic                       error_o,
    output logic                       locked_o,
    output logic [CNT_WIDTH-1:0]       crc_err_cnt_o,
    output logic [CNT_WIDTH-1:0]       len_err_cnt_o,
    output logic [CNT_WIDTH-1:0]       sym_err_cnt_o
);

    localparam int PW          = PAYLOAD_BYTES * 8;
    localparam int FRAME_BYTES = PAYLOAD_BYTES + 2;
    localparam int BW          = $clog2(FRAME_BYTES + 1);
    localparam int GW          = $clog2(LOCK_FRAMES + 1);
    localparam int UW          = $clog2(UNLOCK_ERRORS + 1);
    localparam int WW          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {HUNT, COLLECT, CHECK, TRAIL} state_t;

    state_t          state;
    logic [BW-1:0]   byte_cnt;
    logic [15:0]     crc;
    logic [PW-1:0]   shadow;
    logic [GW-1:0]   good_run;
    logic [UW-1:0]   bad_run;
    logic [WW-1:0]   watchdog;

    logic sym_err, sym_comma, sym_data;
    logic ev_good, ev_crc, ev_len, ev_sym, ev_err;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        return r;
    endfunction

    // Decode errors outrank the comma flag.
    assign sym_err   = word_tick_i & error_i;
    assign sym_comma = word_tick_i & ~error_i & comma_i;
    assign sym_data  = word_tick_i & ~error_i & ~comma_i;

    always_comb begin
        ev_good = 1'b0;
        ev_crc  = 1'b0;
        ev_len  = 1'b0;
        ev_sym  = 1'b0;
        case (state)
            COLLECT: begin
                if (sym_err)        ev_sym = 1'b1;
                else if (sym_comma) ev_len = 1'b1;
            end
            CHECK: begin
                if (crc == 16'h0000) ev_good = 1'b1;
                else                 ev_crc  = 1'b1;
            end
            TRAIL: begin
                if (sym_err)       ev_sym = 1'b1;
                else if (sym_data) ev_len = 1'b1;
            end
            default: ;
        endcase
        ev_err = ev_crc | ev_len | ev_sym;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            byte_cnt     <= '0;
            crc          <= '0;
            shadow       <= '0;
            payload_o    <= '0;
            frame_tick_o <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            frame_tick_o <= ev_good;
            error_o      <= ev_err;
            if (ev_good) payload_o <= shadow;
            case (state)
                HUNT: begin
                    if (sym_comma) begin
                        state    <= COLLECT;
                        byte_cnt <= '0;
                        crc      <= '0;
                    end
                end
                COLLECT: begin
                    if (sym_err) begin
                        state <= HUNT;
                    end else if (sym_comma) begin
                        byte_cnt <= '0;
                        crc      <= '0;
                    end else if (sym_data) begin
                        crc <= crc_byte(crc, data_i);
                        // Only payload bytes enter the shadow; a restart refills it completely.
                        if (byte_cnt < BW'(PAYLOAD_BYTES)) shadow <= (shadow << 8) | PW'(data_i);
                        if (byte_cnt == BW'(FRAME_BYTES - 1)) state <= CHECK;
                        else byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                CHECK: state <= (crc == 16'h0000) ? TRAIL : HUNT;
                TRAIL: begin
                    if (sym_comma) begin
                        state    <= COLLECT;
                        byte_cnt <= '0;
                        crc      <= '0;
                    end else if (sym_err || sym_data) begin
                        state <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_counters_i) begin
            crc_err_cnt_o <= '0;
            len_err_cnt_o <= '0;
            sym_err_cnt_o <= '0;
        end else begin
            if (ev_crc && crc_err_cnt_o != '1) crc_err_cnt_o <= crc_err_cnt_o + 1'b1;
            if (ev_len && len_err_cnt_o != '1) len_err_cnt_o <= len_err_cnt_o + 1'b1;
            if (ev_sym && sym_err_cnt_o != '1) sym_err_cnt_o <= sym_err_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_o <= 1'b0;
            good_run <= '0;
            bad_run  <= '0;
            watchdog <= '0;
        end else begin
            if (ev_good) begin
                bad_run <= '0;
                if (good_run != GW'(LOCK_FRAMES)) good_run <= good_run + 1'b1;
                if (good_run >= GW'(LOCK_FRAMES - 1)) locked_o <= 1'b1;
            end else if (ev_err) begin
                good_run <= '0;
                if (bad_run != UW'(UNLOCK_ERRORS)) bad_run <= bad_run + 1'b1;
                if (bad_run >= UW'(UNLOCK_ERRORS - 1)) locked_o <= 1'b0;
            end
            // Watchdog only runs while locked; expiry also forgets the good run.
            if (ev_good) begin
                watchdog <= '0;
            end else if (locked_o) begin
                if (watchdog == WW'(TIMEOUT_CYCLES - 1)) begin
                    locked_o <= 1'b0;
                    good_run <= '0;
                    watchdog <= '0;
                end else begin
                    watchdog <= watchdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_receiver_multi.sv
// tb/tb_frame_receiver_multi.sv - self-checking bench for frame_receiver_multi against a frame-level model
module tb_frame_receiver_multi;

    localparam int PB      = 9;
    localparam int CW      = 2;
    localparam int LOCKN   = 4;
    localparam int UNLOCKN = 3;
    localparam int TMO     = 1000;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          word_tick_i;
    logic          comma_i;
    logic [7:0]    data_i;
    logic          error_i;
    logic          clear_counters_i;
    logic          frame_tick_o;
    logic [PB*8-1:0] payload_o;
    logic          error_o;
    logic          locked_o;
    logic [CW-1:0] crc_err_cnt_o;
    logic [CW-1:0] len_err_cnt_o;
    logic [CW-1:0] sym_err_cnt_o;

    frame_receiver_multi #(
        .PAYLOAD_BYTES(PB),
        .CNT_WIDTH(CW),
        .LOCK_FRAMES(LOCKN),
        .UNLOCK_ERRORS(UNLOCKN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .word_tick_i(word_tick_i),
        .comma_i(comma_i),
        .data_i(data_i),
        .error_i(error_i),
        .clear_counters_i(clear_counters_i),
        .frame_tick_o(frame_tick_o),
        .payload_o(payload_o),
        .error_o(error_o),
        .locked_o(locked_o),
        .crc_err_cnt_o(crc_err_cnt_o),
        .len_err_cnt_o(len_err_cnt_o),
        .sym_err_cnt_o(sym_err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [71:0] m_payload;
    int          m_crc, m_len, m_sym, m_good_run, m_bad_run;
    bit          m_locked;

    logic [71:0] std_pl = 72'h313233343536373839;
    logic [71:0] pl;
    logic [95:0] rnd;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [71:0] p);
        logic [15:0] r;
        logic        fb;
        r = 16'h0000;
        for (int i = 0; i < 72; i++) begin
            fb = r[15] ^ p[71-i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    task automatic m_reset();
        m_payload = '0; m_crc = 0; m_len = 0; m_sym = 0;
        m_good_run = 0; m_bad_run = 0; m_locked = 0;
    endtask

    task automatic m_good(input logic [71:0] p);
        m_payload = p;
        m_good_run++;
        m_bad_run = 0;
        if (m_good_run >= LOCKN) m_locked = 1;
    endtask

    // kind: 0 CRC, 1 length, 2 symbol
    task automatic m_err(input int kind);
        if (kind == 0 && m_crc < CNT_MAX) m_crc++;
        if (kind == 1 && m_len < CNT_MAX) m_len++;
        if (kind == 2 && m_sym < CNT_MAX) m_sym++;
        m_good_run = 0;
        m_bad_run++;
        if (m_bad_run >= UNLOCKN) m_locked = 0;
    endtask

    task automatic check_state(input string tag, input bit exp_tick, input bit exp_err);
        chk({tag, ".tick"},    72'(frame_tick_o),  72'(exp_tick));
        chk({tag, ".error"},   72'(error_o),       72'(exp_err));
        chk({tag, ".payload"}, payload_o,          m_payload);
        chk({tag, ".locked"},  72'(locked_o),      72'(m_locked));
        chk({tag, ".crc_cnt"}, 72'(crc_err_cnt_o), 72'(m_crc));
        chk({tag, ".len_cnt"}, 72'(len_err_cnt_o), 72'(m_len));
        chk({tag, ".sym_cnt"}, 72'(sym_err_cnt_o), 72'(m_sym));
    endtask

    task automatic sym(input logic c, input logic [7:0] d, input logic e);
        word_tick_i = 1'b1; comma_i = c; data_i = d; error_i = e;
        @(posedge clk); #1;
        word_tick_i = 1'b0; comma_i = 1'b0; error_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Returns in the cycle two after the last CRC byte, where the verdict is visible.
    task automatic send_frame(input string tag, input logic [71:0] p, input logic [15:0] c,
                              input bit lead, input bit spaced);
        logic [87:0] all;
        all = {p, c};
        if (lead) begin
            sym(1'b1, 8'hBC, 1'b0);
            if (spaced) idle(1);
        end
        for (int i = 0; i < PB + 2; i++) begin
            sym(1'b0, all[87-8*i -: 8], 1'b0);
            if (spaced && i < PB + 1) idle(1);
        end
        chk({tag, ".t1_tick"}, 72'(frame_tick_o), 72'(0));
        chk({tag, ".t1_error"}, 72'(error_o), 72'(0));
        @(posedge clk); #1;
        if (c == crc_of(p)) begin
            m_good(p);
            check_state(tag, 1'b1, 1'b0);
        end else begin
            m_err(0);
            check_state(tag, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; word_tick_i = 1'b0; comma_i = 1'b0; data_i = 8'h00;
        error_i = 1'b0; clear_counters_i = 1'b0;
        m_reset();
        idle(3);
        check_state("reset", 1'b0, 1'b0);
        reset = 1'b0;
        idle(2);

        send_frame("std_good", std_pl, 16'hFEE8, 1'b1, 1'b0);
        idle(1);
        chk("std_good.pulse_end", 72'(frame_tick_o), 72'(0));

        send_frame("std_badcrc", std_pl, 16'hFEE9, 1'b1, 1'b0);
        idle(1);
        chk("std_badcrc.pulse_end", 72'(error_o), 72'(0));

        sym(1'b1, 8'hBC, 1'b0);
        for (int i = 0; i < 5; i++) sym(1'b0, 8'h40 + 8'(i), 1'b0);
        sym(1'b1, 8'hBC, 1'b0);
        m_err(1);
        check_state("short", 1'b0, 1'b1);
        send_frame("after_short", std_pl, 16'hFEE8, 1'b0, 1'b0);

        sym(1'b0, 8'h55, 1'b0);
        m_err(1);
        check_state("long", 1'b0, 1'b1);
        sym(1'b0, 8'h66, 1'b0);
        sym(1'b0, 8'h77, 1'b0);
        check_state("hunt_ignores", 1'b0, 1'b0);
        send_frame("after_long", std_pl, 16'hFEE8, 1'b1, 1'b1);

        sym(1'b1, 8'hBC, 1'b0);
        for (int i = 0; i < 3; i++) sym(1'b0, 8'h10 + 8'(i), 1'b0);
        sym(1'b1, 8'hBC, 1'b1);
        m_err(2);
        check_state("symerr", 1'b0, 1'b1);
        sym(1'b0, 8'h00, 1'b1);
        check_state("symerr_in_hunt", 1'b0, 1'b0);

        for (int f = 0; f < LOCKN; f++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            send_frame($sformatf("lock_%0d", f), rnd[71:0], crc_of(rnd[71:0]), 1'b1, 1'b1);
        end
        for (int f = 0; f < UNLOCKN; f++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            send_frame($sformatf("unlock_%0d", f), rnd[71:0], crc_of(rnd[71:0]) ^ 16'h0100, 1'b1, 1'b0);
        end

        clear_counters_i = 1'b1;
        idle(1);
        clear_counters_i = 1'b0;
        m_crc = 0; m_len = 0; m_sym = 0;
        check_state("clear", 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            send_frame($sformatf("sat_%0d", f), std_pl, 16'hFEE9, 1'b1, 1'b0);
        end

        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b0, 8'h01, 1'b0);
        sym(1'b0, 8'h02, 1'b0);
        clear_counters_i = 1'b1;
        sym(1'b0, 8'h03, 1'b1);
        clear_counters_i = 1'b0;
        m_err(2);
        m_crc = 0; m_len = 0; m_sym = 0;
        check_state("clear_vs_err", 1'b0, 1'b1);

        for (int f = 0; f < LOCKN; f++) begin
            send_frame($sformatf("tlock_%0d", f), std_pl, 16'hFEE8, 1'b1, 1'b0);
        end
        chk("timeout.locked_at_start", 72'(locked_o), 72'(1));
        idle(TMO - 1);
        chk("timeout.locked_at_999", 72'(locked_o), 72'(1));
        idle(1);
        m_locked = 0; m_good_run = 0;
        check_state("timeout_1000", 1'b0, 1'b0);

        sym(1'b1, 8'hBC, 1'b0);
        for (int i = 0; i < 4; i++) sym(1'b0, 8'hA0 + 8'(i), 1'b0);
        reset = 1'b1;
        idle(1);
        m_reset();
        check_state("reset_midframe", 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) sym(1'b0, 8'hB0 + 8'(i), 1'b0);
        check_state("after_reset_bytes", 1'b0, 1'b0);
        send_frame("after_reset_good", std_pl, 16'hFEE8, 1'b1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int  kind;
            int  k;
            bit  sp;
            kind = $urandom_range(4, 0);
            sp   = 1'($urandom_range(1, 0));
            rnd  = {$urandom(), $urandom(), $urandom()};
            pl   = rnd[71:0];
            case (kind)
                0: send_frame($sformatf("r%0d_good", it), pl, crc_of(pl), 1'b1, sp);
                1: send_frame($sformatf("r%0d_crc", it), pl,
                              crc_of(pl) ^ (16'h0001 << $urandom_range(15, 0)), 1'b1, sp);
                2: begin
                    k = $urandom_range(10, 1);
                    sym(1'b1, 8'hBC, 1'b0);
                    for (int i = 0; i < k; i++) sym(1'b0, 8'($urandom()), 1'b0);
                    sym(1'b1, 8'hBC, 1'b0);
                    m_err(1);
                    check_state($sformatf("r%0d_short", it), 1'b0, 1'b1);
                    send_frame($sformatf("r%0d_short_next", it), pl, crc_of(pl), 1'b0, sp);
                end
                3: begin
                    send_frame($sformatf("r%0d_long_pre", it), pl, crc_of(pl), 1'b1, sp);
                    sym(1'b0, 8'($urandom()), 1'b0);
                    m_err(1);
                    check_state($sformatf("r%0d_long", it), 1'b0, 1'b1);
                end
                default: begin
                    k = $urandom_range(10, 0);
                    sym(1'b1, 8'hBC, 1'b0);
                    for (int i = 0; i < k; i++) sym(1'b0, 8'($urandom()), 1'b0);
                    sym(1'($urandom_range(1, 0)), 8'($urandom()), 1'b1);
                    m_err(2);
                    check_state($sformatf("r%0d_sym", it), 1'b0, 1'b1);
                end
            endcase
            idle($urandom_range(2, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
